alu_cmd_sequencer: RTL and testbench

Sequential command front-end for the 8-bit ALU_total datapath. It accepts one ALU command per valid/ready handshake and drives registered Sel/A/B/Carryin into the ALU. It captures Y into an accumulator, optionally iterating the same operation with Y fed back to A, then presents the result on a valid/ready output port. The ALU is opaque to this block: Sel codes pass through without decoding.

---
 rtl/alu_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for an 8-bit ALU: accepts one command per handshake, drives
// registered ALU inputs, iterates with Y fed back to A, and returns the result.
module alu_cmd_sequencer #(
  parameter int unsigned ALU_LAT = 0,
  parameter int unsigned REP_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_sel,
  input  logic             cmd_cin,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_use_acc,
  input  logic [REP_W-1:0] cmd_repeat,
  output logic [4:0]       alu_sel,
  output logic             alu_cin,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [7:0]       acc,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [2:0] LAT = 3'(ALU_LAT);

  state_e           state_q, state_d;
  logic [4:0]       alu_sel_q, alu_sel_d;
  logic             alu_cin_q, alu_cin_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [7:0]       done_cnt_q, done_cnt_d;
  logic [2:0]       wait_cnt_q, wait_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  always_comb begin
    state_d    = state_q;
    alu_sel_d  = alu_sel_q;
    alu_cin_d  = alu_cin_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    done_cnt_d = done_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          alu_sel_d  = cmd_sel;
          alu_cin_d  = cmd_cin;
          alu_b_d    = cmd_b;
          alu_a_d    = cmd_use_acc ? acc_q : cmd_a;
          rep_cnt_d  = cmd_repeat;
          wait_cnt_d = LAT;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end else begin
          acc_d = alu_y;
          if (rep_cnt_q == '0) begin
            res_data_d = alu_y;
            state_d    = S_RESP;
          end else begin
            // Feed Y back to A; sel, b and cin stay as loaded.
            alu_a_d    = alu_y;
            rep_cnt_d  = rep_cnt_q - 1'b1;
            wait_cnt_d = LAT;
          end
        end
      end
      S_RESP: begin
        if (res_ready) begin
          done_cnt_d = done_cnt_q + 8'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      alu_sel_q  <= '0;
      alu_cin_q  <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      acc_q      <= '0;
      res_data_q <= '0;
      done_cnt_q <= '0;
      wait_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      alu_sel_q  <= alu_sel_d;
      alu_cin_q  <= alu_cin_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      acc_q      <= acc_d;
      res_data_q <= res_data_d;
      done_cnt_q <= done_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_RESP);
  assign alu_sel   = alu_sel_q;
  assign alu_cin   = alu_cin_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign acc       = acc_q;
  assign res_data  = res_data_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a driver pushes model results into a
// queue, a monitor pops and compares on each result, a checker tracks ALU inputs.
module tb_alu_cmd_sequencer;
  localparam int unsigned LAT = 2;
  localparam int unsigned RW  = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_cin = 1'b0, cmd_use_acc = 1'b0, res_ready = 1'b0;
  logic          cmd_ready, alu_cin, res_valid, busy;
  logic [4:0]    cmd_sel = '0, alu_sel;
  logic [7:0]    cmd_a = '0, cmd_b = '0, alu_a, alu_b, alu_y, res_data, acc, done_cnt;
  logic [RW-1:0] cmd_repeat = '0;

  int          checks = 0, errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer #(.ALU_LAT(LAT), .REP_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_cin(cmd_cin), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc), .cmd_repeat(cmd_repeat), .alu_sel(alu_sel),
    .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .acc(acc), .busy(busy), .done_cnt(done_cnt)
  );

  // ALU stub: 0 add with carry, 1 shift left, 2 xor, 3 subtract.
  function automatic logic [7:0] stub(input logic [4:0] sel, input logic [7:0] a,
                                      input logic [7:0] b, input logic cin);
    int unsigned r;
    case (sel)
      5'd0:    r = (int'(a) + int'(b) + int'(cin)) % 256;
      5'd1:    r = (int'(a) * 2) % 256;
      5'd2:    r = int'(a ^ b);
      default: r = (int'(a) - int'(b) + 256) % 256;
    endcase
    return 8'(r);
  endfunction

  always_comb alu_y = stub(alu_sel, alu_a, alu_b, alu_cin);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0]  res;
    int unsigned k;
    int unsigned rep;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [7:0]  model_acc = '0, model_done = '0;
  bit          model_idle = 1'b1, in_resp = 1'b0;
  logic [7:0]  a_seq[16];
  bit          cur_active = 1'b0;
  int unsigned cur_k = 0, cur_rep = 0;
  logic [4:0]  cur_sel = '0;
  logic [7:0]  cur_b = '0;
  logic        cur_cin = 1'b0;
  int          rr_mode = 2; // 0 random, 1 hold low, 2 hold high

  always begin
    @(posedge clk);
    #2;
    res_ready = (rr_mode == 1) ? 1'b0 : (rr_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  task automatic wait_idle();
    int n = 0;
    while (!model_idle && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!model_idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [4:0] sel, input logic cin, input logic [7:0] a,
                       input logic [7:0] b, input logic use_acc, input int unsigned rep);
    int         n = 0;
    logic [7:0] av;
    @(negedge clk);
    while (!model_idle && n < 3000) begin
      cmd_valid = 1'b1;
      cmd_sel = 5'($urandom_range(0, 3)); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      cmd_cin = 1'($urandom); cmd_use_acc = 1'($urandom); cmd_repeat = RW'($urandom);
      check("ready_while_busy", 32'(cmd_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    if (!model_idle) begin
      check("issue_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    check("ready_when_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_sel = sel; cmd_cin = cin; cmd_a = a; cmd_b = b;
    cmd_use_acc = use_acc; cmd_repeat = RW'(rep);
    av = use_acc ? model_acc : a;
    for (int unsigned i = 0; i <= rep; i++) begin
      a_seq[i] = av;
      av = stub(sel, av, b, cin);
    end
    model_acc = av;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cur_k = cyc; cur_rep = rep; cur_sel = sel; cur_b = b; cur_cin = cin;
    cur_active = 1'b1;
    model_idle = 1'b0;
    exp_q.push_back('{res: av, k: cyc, rep: rep});
  endtask

  // Monitor: pops expected results when the DUT presents one.
  always begin
    @(negedge clk);
    if (rst_n && res_valid) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(res_valid), 32'd0);
          cur = '{res: res_data, k: 0, rep: 0};
        end else begin
          cur = exp_q.pop_front();
          check("res_latency", cyc, cur.k + (cur.rep + 1) * (LAT + 1));
          check("res_acc", 32'(acc), 32'(cur.res));
          check("done_before", 32'(done_cnt), 32'(model_done));
        end
      end
      check("res_data", 32'(res_data), 32'(cur.res));
      check("ready_in_resp", 32'(cmd_ready), 32'd0);
      if (res_ready) begin
        model_done = model_done + 8'd1;
        @(posedge clk);
        #1;
        check("done_cnt", 32'(done_cnt), 32'(model_done));
        check("valid_dropped", 32'(res_valid), 32'd0);
        check("ready_after", 32'(cmd_ready), 32'd1);
        in_resp = 1'b0; cur_active = 1'b0; model_idle = 1'b1;
      end
    end
  end

  // ALU input tracker: A steps through the feedback chain every LAT+1 edges.
  always begin
    @(negedge clk);
    if (rst_n && cur_active) begin
      int unsigned idx;
      idx = (cyc - cur_k) / (LAT + 1);
      if (idx > cur_rep) idx = cur_rep;
      check("alu_a", 32'(alu_a), 32'(a_seq[idx]));
      check("alu_sel", 32'(alu_sel), 32'(cur_sel));
      check("alu_b", 32'(alu_b), 32'(cur_b));
      check("alu_cin", 32'(alu_cin), 32'(cur_cin));
      check("busy", 32'(busy), 32'd1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a command offered.
    cmd_valid = 1'b1; cmd_a = 8'h55; cmd_b = 8'h11; cmd_sel = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_done", 32'(done_cnt), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    cmd_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("no_accept_in_reset", 32'(busy), 32'd0);

    // Reset during the second iteration of a repeat=5 command.
    cmd_valid = 1'b1; cmd_sel = 5'd0; cmd_a = 8'h05; cmd_b = 8'h03; cmd_cin = 1'b0;
    cmd_use_acc = 1'b0; cmd_repeat = RW'(5);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("acc_mid_op", 32'(acc), 32'h08);
    check("busy_mid_op", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_acc", 32'(acc), 32'd0);
    check("midrst_valid", 32'(res_valid), 32'd0);
    repeat (20) @(negedge clk);
    check("midrst_done", 32'(done_cnt), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    // Directed commands.
    rr_mode = 2;
    issue(5'd0, 1'b0, 8'h81, 8'h01, 1'b0, 0);
    issue(5'd0, 1'b0, 8'hFF, 8'h00, 1'b0, 0);
    issue(5'd0, 1'b1, 8'h00, 8'h00, 1'b1, 0);
    wait_idle();
    check("acc_wrap", 32'(acc), 32'h00);
    issue(5'd1, 1'b0, 8'h03, 8'h00, 1'b0, 3);
    wait_idle();
    check("shift_result", 32'(acc), 32'h30);

    // Backpressure: hold res_ready low while junk commands are offered.
    rr_mode = 1;
    issue(5'd3, 1'b0, 8'h10, 8'h20, 1'b0, 1);
    fork
      begin
        int n = 0;
        while (!res_valid && n < 100) begin
          @(posedge clk);
          n++;
        end
        repeat (5) @(posedge clk);
        rr_mode = 2;
      end
    join_none
    issue(5'd2, 1'b0, 8'hA5, 8'h0F, 1'b1, 2);

    // Random traffic with random backpressure.
    rr_mode = 0;
    for (int i = 0; i < 60; i++)
      issue(5'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), $urandom_range(0, 3));
    rr_mode = 2;
    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
